// File: rtl/addertree_pkg.sv
// addertree_pkg: sizing helpers and round-half-up/saturate helper shared by the adder tree
package addertree_pkg;
  typedef struct packed {
    logic sat;
    logic signed [63:0] val;
  } rs_t;
  function automatic int num_levels(input int n);
    return $clog2(n);
  endfunction
  function automatic int sum_width(input int iw, input int n);
    return iw + num_levels(n);
  endfunction
  function automatic int pipe_latency(input int n, input int reg_every);
    return (num_levels(n) + reg_every - 1) / reg_every + 1;
  endfunction
  function automatic rs_t round_sat(input logic signed [63:0] v, input int shift, input int ow);
    logic signed [63:0] r, hi, lo;
    r = (v + (shift > 0 ? (64'sd1 <<< (shift - 1)) : 64'sd0)) >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return '{sat: (r > hi) || (r < lo), val: (r > hi) ? hi : ((r < lo) ? lo : r)};
  endfunction
endpackage

// File: rtl/addertree_level.sv
// addertree_level: one tree level (clk,resetn,advance,in_valid,din -> out_valid,dout), pairwise signed add, optional register
module addertree_level #(
  parameter int N = 2,
  parameter int IW = 16,
  parameter int REGISTERED = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic advance,
  input  logic in_valid,
  input  logic [N*IW-1:0] din,
  output logic out_valid,
  output logic [((N+1)/2)*(IW+1)-1:0] dout
);
  logic [((N+1)/2)*(IW+1)-1:0] comb;
  for (genvar j = 0; j < (N + 1) / 2; j++) begin : g_pair
    if (2 * j + 1 < N) begin : g_add
      assign comb[j*(IW+1) +: IW+1] = (IW+1)'($signed(din[2*j*IW +: IW])) + (IW+1)'($signed(din[(2*j+1)*IW +: IW]));
    end else begin : g_pass
      assign comb[j*(IW+1) +: IW+1] = (IW+1)'($signed(din[2*j*IW +: IW]));
    end
  end
  if (REGISTERED != 0) begin : g_reg
    always_ff @(posedge clk)
      if (!resetn) out_valid <= 1'b0;
      else if (advance) out_valid <= in_valid;
    always_ff @(posedge clk)
      if (advance) dout <= comb;
  end else begin : g_comb
    assign out_valid = in_valid;
    assign dout = comb;
  end
endmodule

// File: rtl/addertree_pipe.sv
// addertree_pipe: pipelined signed adder tree, valid/ready global stall, scaled output (clk,resetn; in_valid,in_ready,inputd -> out_valid,out_ready,sum,sat_flag); ADDERTREE_ROUND_SAT_EN selects round-half-up + saturate
module addertree_pipe
  import addertree_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int NUM_INPUTS = 53,
  parameter int REG_EVERY = 1,
  parameter int OUT_WIDTH = 22,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] inputd,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [OUT_WIDTH-1:0] sum,
  output logic sat_flag
);
  localparam int LEVELS = num_levels(NUM_INPUTS);
  localparam int SUM_WIDTH = sum_width(INPUT_WIDTH, NUM_INPUTS);
  localparam int XW = SUM_WIDTH > OUT_WIDTH ? SUM_WIDTH : OUT_WIDTH;
  logic advance, fin_valid, sat_next;
  logic signed [SUM_WIDTH-1:0] full_sum;
  logic signed [OUT_WIDTH-1:0] scaled;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  if (LEVELS == 0) begin : g_bypass
    assign full_sum = inputd;
    assign fin_valid = in_valid;
  end else begin : g_tree
    for (genvar k = 0; k < LEVELS; k++) begin : lv
      localparam int NI = (NUM_INPUTS + (1 << k) - 1) >> k;
      localparam int NO = (NI + 1) / 2;
      logic [NI*(INPUT_WIDTH+k)-1:0] din;
      logic [NO*(INPUT_WIDTH+k+1)-1:0] dout;
      logic vin, vout;
      if (k == 0) begin : g_first
        assign din = inputd;
        assign vin = in_valid;
      end else begin : g_next
        assign din = lv[k-1].dout;
        assign vin = lv[k-1].vout;
      end
      addertree_level #(
        .N(NI),
        .IW(INPUT_WIDTH + k),
        .REGISTERED((((k + 1) % REG_EVERY) == 0 || k == LEVELS - 1) ? 1 : 0)
      ) u_level (
        .clk(clk),
        .resetn(resetn),
        .advance(advance),
        .in_valid(vin),
        .din(din),
        .out_valid(vout),
        .dout(dout)
      );
    end
    assign full_sum = lv[LEVELS-1].dout;
    assign fin_valid = lv[LEVELS-1].vout;
  end
`ifdef ADDERTREE_ROUND_SAT_EN
  rs_t rs;
  assign rs = round_sat(64'(full_sum), SHIFT, OUT_WIDTH);
  assign scaled = OUT_WIDTH'(rs.val);
  assign sat_next = rs.sat;
`else
  assign scaled = OUT_WIDTH'(XW'(full_sum) >>> SHIFT);
  assign sat_next = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!resetn) begin
      out_valid <= 1'b0;
      sum <= '0;
      sat_flag <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_valid;
      sum <= scaled;
      sat_flag <= sat_next;
    end
endmodule

// File: tb/tb_addertree_pipe.sv
// tb_addertree_pipe: directed self-checking bench for addertree_pipe across four parameterisations
module tb_addertree_pipe;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic iv0 = 0, ir0, ov0, or0 = 1, sf0;
  logic [52:0][15:0] d0 = '0;
  logic signed [21:0] s0;
  logic iv1 = 0, ir1, ov1, or1 = 1, sf1;
  logic [52:0][15:0] d1 = '0;
  logic signed [15:0] s1;
  logic iv2 = 0, ir2, ov2, or2 = 1, sf2;
  logic [52:0][15:0] d2 = '0;
  logic signed [21:0] s2;
  logic iv3 = 0, ir3, ov3, or3 = 1, sf3;
  logic [0:0][15:0] d3 = '0;
  logic signed [21:0] s3;
  int q[$];

  addertree_pipe u0 (.clk(clk), .resetn(resetn), .in_valid(iv0), .in_ready(ir0), .inputd(d0),
    .out_valid(ov0), .out_ready(or0), .sum(s0), .sat_flag(sf0));
  addertree_pipe #(.OUT_WIDTH(16)) u1 (.clk(clk), .resetn(resetn), .in_valid(iv1), .in_ready(ir1),
    .inputd(d1), .out_valid(ov1), .out_ready(or1), .sum(s1), .sat_flag(sf1));
  addertree_pipe #(.SHIFT(2), .REG_EVERY(2)) u2 (.clk(clk), .resetn(resetn), .in_valid(iv2), .in_ready(ir2),
    .inputd(d2), .out_valid(ov2), .out_ready(or2), .sum(s2), .sat_flag(sf2));
  addertree_pipe #(.NUM_INPUTS(1)) u3 (.clk(clk), .resetn(resetn), .in_valid(iv3), .in_ready(ir3),
    .inputd(d3), .out_valid(ov3), .out_ready(or3), .sum(s3), .sat_flag(sf3));

  always @(negedge clk)
    if (ov0 && or0) q.push_back(int'(s0));

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++; if (s0 !== 22'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", s0); end
    checks++; if (sf0 !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sf0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    checks++; if (ov2 !== 1'b0 || ov3 !== 1'b0) begin errors++; $display("FAIL reset_other_valid got %b%b want 00", ov2, ov3); end
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ones;
    int n;
    for (int j = 0; j < 53; j++) d0[j] = 16'd1;
    iv0 = 1;
    @(posedge clk);
    #1;
    iv0 = 0;
    n = 1;
    while (!ov0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 7) begin errors++; $display("FAIL ones_latency got %0d want 7", n); end
    checks++; if (int'(s0) != 53) begin errors++; $display("FAIL ones_sum got %0d want 53", s0); end
    @(posedge clk);
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ones_pulse got %b want 0", ov0); end
  endtask

  task automatic test_back_to_back;
    int base, n;
    int exp[8];
    base = q.size();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 53; j++) d0[j] = (i == 0) ? 16'h8000 : 16'(i * 500 + j);
      exp[i] = (i == 0) ? -1736704 : 53 * i * 500 + 1378;
      iv0 = 1;
      @(posedge clk);
      #1;
    end
    iv0 = 0;
    n = 0;
    while (q.size() < base + 8 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (q.size() != base + 8) begin errors++; $display("FAIL b2b_count got %0d want %0d", q.size() - base, 8); end
    for (int i = 0; i < 8; i++)
      if (q.size() > base + i) begin
        checks++;
        if (q[base+i] != exp[i]) begin errors++; $display("FAIL b2b_sum%0d got %0d want %0d", i, q[base+i], exp[i]); end
      end
  endtask

  task automatic test_backpressure;
    int base, idx, c, ns;
    logic acc, prev;
    logic signed [21:0] held;
    base = q.size();
    idx = 0;
    c = 0;
    ns = 0;
    prev = 0;
    held = '0;
    while ((idx < 10 || q.size() < base + 10) && c < 80) begin
      or0 = !(c >= 9 && c < 14);
      for (int j = 0; j < 53; j++) d0[j] = 16'(-300 * idx + j);
      iv0 = (idx < 10);
      @(negedge clk);
      acc = iv0 && ir0;
      if (ov0 && !or0) begin
        ns++;
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", ir0); end
        if (prev) begin
          checks++; if (s0 !== held) begin errors++; $display("FAIL bp_hold got %0d want %0d", s0, held); end
        end
        held = s0;
        prev = 1;
      end else prev = 0;
      @(posedge clk);
      #1;
      if (acc) idx++;
      c++;
    end
    iv0 = 0;
    or0 = 1;
    checks++; if (ns != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", ns); end
    checks++; if (q.size() != base + 10) begin errors++; $display("FAIL bp_count got %0d want 10", q.size() - base); end
    for (int i = 0; i < 10; i++)
      if (q.size() > base + i) begin
        checks++;
        if (q[base+i] != 53 * (-300 * i) + 1378) begin
          errors++; $display("FAIL bp_sum%0d got %0d want %0d", i, q[base+i], 53 * (-300 * i) + 1378);
        end
      end
  endtask

  task automatic test_reset_mid;
    int base;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 53; j++) d0[j] = 16'(c + 1);
      iv0 = 1;
      @(posedge clk);
      #1;
    end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL mid_valid_before got %b want 1", ov0); end
    iv0 = 0;
    resetn = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL mid_valid_after got %b want 0", ov0); end
    checks++; if (s0 !== 22'sd0) begin errors++; $display("FAIL mid_sum_after got %0d want 0", s0); end
    base = q.size();
    repeat (15) @(posedge clk);
    #1;
    checks++; if (q.size() != base) begin errors++; $display("FAIL mid_stale got %0d want 0", q.size() - base); end
  endtask

  task automatic test_saturate;
    int n, es, ef;
`ifdef ADDERTREE_ROUND_SAT_EN
    es = 32767;
    ef = 1;
`else
    es = -12536;
    ef = 0;
`endif
    for (int j = 0; j < 53; j++) d1[j] = 16'd1000;
    iv1 = 1;
    @(posedge clk);
    #1;
    iv1 = 0;
    n = 1;
    while (!ov1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 7) begin errors++; $display("FAIL sat_latency got %0d want 7", n); end
    checks++; if (int'(s1) != es) begin errors++; $display("FAIL sat_sum got %0d want %0d", s1, es); end
    checks++; if (int'(sf1) != ef) begin errors++; $display("FAIL sat_flag got %0d want %0d", sf1, ef); end
  endtask

  task automatic test_shift;
    int n;
    int v[2];
    int e[2];
    v[0] = 6;
    v[1] = -6;
`ifdef ADDERTREE_ROUND_SAT_EN
    e[0] = 2;
    e[1] = -1;
`else
    e[0] = 1;
    e[1] = -2;
`endif
    for (int t = 0; t < 2; t++) begin
      d2 = '0;
      d2[0] = 16'(v[t]);
      iv2 = 1;
      @(posedge clk);
      #1;
      iv2 = 0;
      n = 1;
      while (!ov2 && n < 30) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL shift_latency%0d got %0d want 4", t, n); end
      checks++; if (int'(s2) != e[t]) begin errors++; $display("FAIL shift_sum%0d got %0d want %0d", t, s2, e[t]); end
      checks++; if (sf2 !== 1'b0) begin errors++; $display("FAIL shift_flag%0d got %b want 0", t, sf2); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single;
    d3[0] = 16'hFFFB;
    iv3 = 1;
    @(posedge clk);
    #1;
    checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", ov3); end
    checks++; if (int'(s3) != -5) begin errors++; $display("FAIL single_sum0 got %0d want -5", s3); end
    d3[0] = 16'h7FFF;
    @(posedge clk);
    #1;
    iv3 = 0;
    checks++; if (int'(s3) != 32767) begin errors++; $display("FAIL single_sum1 got %0d want 32767", s3); end
    @(posedge clk);
    #1;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", ov3); end
  endtask

  initial begin
    test_reset;
    test_ones;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_saturate;
    test_shift;
    test_single;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
